// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection blocks: light codes, walk FSM
// encoding and default timing constants.
package traffic_pkg;

    typedef enum logic [1:0] {
        NAN   = 2'd0,
        GREEN = 2'd1,
        YEL   = 2'd2,
        RED   = 2'd3
    } light_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2,
        LOCKOUT = 2'd3
    } walk_state_t;

    localparam int DEB_CYCLES_DEF    = 16;
    localparam int LOCKOUT_TICKS_DEF = 3;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a counting debouncer; rise pulses on the
// same edge the debounced level goes high.
module sync_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;

    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;
    logic          mismatch;
    logic          flip;

    assign mismatch = sync_pipe[1] ^ level;
    assign flip     = mismatch && (cnt == CW'(DEB_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_pipe <= '0;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], raw};
            // any agreeing sample restarts the count, so glitches never accumulate
            if (!mismatch || flip)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (flip)
                level <= ~level;
            rise <= flip & ~level;
        end
    end

endmodule

// File: rtl/ped_request_conditioner.sv
// Debounces the walk button and vehicle sensor and latches walk requests until
// served, followed by a tick-paced lockout. PRESS_COUNT_EN adds a press counter.
module ped_request_conditioner
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int LOCKOUT_TICKS = LOCKOUT_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       walk_btn,
    input  logic       sensor_raw,
    input  logic       walk_ack,
    output logic       walk_req,
    output logic       sensor_db,
    output logic       sensor_rise,
    output logic [3:0] press_count
);

    localparam int NUM_IN = 2;
    localparam int LW     = $clog2(LOCKOUT_TICKS + 1);

    logic [NUM_IN-1:0] raw_vec;
    logic [NUM_IN-1:0] level_vec;
    logic [NUM_IN-1:0] rise_vec;

    assign raw_vec = {sensor_raw, walk_btn};

    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_vec[i]),
            .level (level_vec[i]),
            .rise  (rise_vec[i])
        );
    end

    assign sensor_db   = level_vec[1];
    assign sensor_rise = rise_vec[1];

    walk_state_t   state, state_n;
    logic [LW-1:0] lock_cnt, lock_n;
    logic          ack_q;
    logic          ack_rise;
    logic          walk_press;

    // rise is only ever seen while the level is high; the AND keeps both tied together
    assign walk_press = rise_vec[0] & level_vec[0];
    assign ack_rise   = walk_ack & ~ack_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
            ack_q    <= 1'b0;
            walk_req <= 1'b0;
        end else begin
            state    <= state_n;
            lock_cnt <= lock_n;
            ack_q    <= walk_ack;
            walk_req <= (state_n == PENDING);
        end
    end

    always_comb begin
        state_n = state;
        lock_n  = lock_cnt;
        case (state)
            IDLE:    if (walk_press) state_n = PENDING;
            PENDING: if (ack_rise) state_n = SERVING;
            SERVING: begin
                if (!walk_ack) begin
                    state_n = LOCKOUT;
                    lock_n  = LW'(LOCKOUT_TICKS);
                end
            end
            LOCKOUT: begin
                if (lock_cnt == '0)
                    state_n = IDLE;
                else if (tick)
                    lock_n = lock_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef PRESS_COUNT_EN
    logic [3:0] press_cnt, press_n;

    always_comb begin
        press_n = press_cnt;
        if (state == PENDING && ack_rise)
            press_n = '0;
        else if (walk_press && (state == IDLE || state == PENDING) && press_cnt != 4'hF)
            press_n = press_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            press_cnt <= '0;
        else
            press_cnt <= press_n;
    end

    assign press_count = press_cnt;
`else
    assign press_count = 4'd0;
`endif

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Scoreboarded bench: a window-based reference model predicts every cycle's
// outputs into a queue that a negedge monitor drains and compares.
module tb_ped_request_conditioner;

    localparam int DEB = 4;
    localparam int LT  = 3;

    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0;
    logic       walk_btn = 1'b0, sensor_raw = 1'b0, walk_ack = 1'b0;
    logic       walk_req, sensor_db, sensor_rise;
    logic [3:0] press_count;

    ped_request_conditioner #(.DEB_CYCLES(DEB), .LOCKOUT_TICKS(LT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .walk_btn(walk_btn),
        .sensor_raw(sensor_raw), .walk_ack(walk_ack), .walk_req(walk_req),
        .sensor_db(sensor_db), .sensor_rise(sensor_rise), .press_count(press_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic       db;
        logic       rs;
        logic [3:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0, tick_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    endtask

    // reference model: raw sample history, debounced levels, request phase
    bit wq[$], sq[$];
    bit m_ws, m_ss, m_wrise, m_srise, m_ackp;
    int m_phase, m_lock, m_cnt;  // phase 0 idle, 1 waiting, 2 served, 3 lockout

    // level toggles when the DEB samples taken 2..DEB+1 edges ago all disagree with it
    function automatic bit flips(input bit q[$], input bit s);
        if (q.size() < DEB + 2) return 1'b0;
        for (int k = 0; k < DEB; k++)
            if (q[q.size() - 3 - k] == s) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        wq.delete(); sq.delete();
        repeat (DEB + 2) begin wq.push_back(1'b0); sq.push_back(1'b0); end
        m_ws = 0; m_ss = 0; m_wrise = 0; m_srise = 0; m_ackp = 0;
        m_phase = 0; m_lock = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit press   = m_wrise;
        bit ackrise = walk_ack && !m_ackp;
        case (m_phase)
            0: if (press) begin m_phase = 1; m_cnt = 1; end
            1: if (ackrise) begin m_phase = 2; m_cnt = 0; end
               else if (press && m_cnt < 15) m_cnt++;
            2: if (!walk_ack) begin m_phase = 3; m_lock = LT; end
            default: if (m_lock == 0) m_phase = 0; else if (tick) m_lock--;
        endcase
        m_ackp = walk_ack;
        wq.push_back(walk_btn);   if (wq.size() > DEB + 2) void'(wq.pop_front());
        sq.push_back(sensor_raw); if (sq.size() > DEB + 2) void'(sq.pop_front());
        if (flips(wq, m_ws)) begin m_ws = !m_ws; m_wrise = m_ws; end else m_wrise = 0;
        if (flips(sq, m_ss)) begin m_ss = !m_ss; m_srise = m_ss; end else m_srise = 0;
    endtask

    // one clock edge: inputs already set by the caller; returns at posedge+1
    task automatic step();
        exp_t e;
        tick = (tick_cnt % 8 == 7);
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        e.wr = (m_phase == 1);
        e.db = m_ss;
        e.rs = m_srise;
`ifdef PRESS_COUNT_EN
        e.pc = 4'(m_cnt);
`else
        e.pc = 4'd0;
`endif
        exp_q.push_back(e);
        tick_cnt++;
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic press(input int hi, input int lo);
        walk_btn = 1'b1; steps(hi);
        walk_btn = 1'b0; steps(lo);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            exp_t a = {walk_req, sensor_db, sensor_rise, press_count};
            chk("cycle_outputs{req,db,rise,cnt}", 32'(a), 32'(e));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int wl = 0, sl = 0, al = 0;
        model_reset();
        steps(3);
        chk("reset_walk_req", 32'(walk_req), 0);
        chk("reset_sensor_db", 32'(sensor_db), 0);
        chk("reset_sensor_rise", 32'(sensor_rise), 0);
        chk("reset_press_count", 32'(press_count), 0);
        reset = 1'b0;
        steps(4);

        // short glitch is rejected
        press(3, 12);
        chk("glitch_walk_req", 32'(walk_req), 0);
        chk("glitch_press_count", 32'(press_count), 0);

        // held press: request after 7 edges, only one request while held
        walk_btn = 1'b1;
        n = 0;
        do begin step(); n++; end while (!walk_req && n < 20);
        chk("walk_req_latency", n, 7);
        steps(100);
        chk("held_walk_req", 32'(walk_req), 1);
        walk_btn = 1'b0; steps(10);

        // service, presses during service and lockout ignored, then accepted
        walk_ack = 1'b1; step();
        chk("ack_clears_req", 32'(walk_req), 0);
        press(6, 6);
        walk_ack = 1'b0; step();
        press(6, 6);
        chk("lockout_req", 32'(walk_req), 0);
        steps(25);
        press(6, 6);
        chk("after_lockout_req", 32'(walk_req), 1);

        // asynchronous reset between edges while a request is pending
        exp_q.delete();
        #2 reset = 1'b1;
        #1 chk("async_reset_req", 32'(walk_req), 0);
        steps(2);
        reset = 1'b0;
        steps(5);
        chk("post_reset_req", 32'(walk_req), 0);

        // sensor follows after 6 edges each way, rise only on 0->1
        sensor_raw = 1'b1;
        n = 0;
        do begin step(); n++; end while (!sensor_db && n < 20);
        chk("sensor_rise_latency", n, 6);
        chk("sensor_rise_pulse", 32'(sensor_rise), 1);
        step();
        chk("sensor_rise_width", 32'(sensor_rise), 0);
        steps(5);
        sensor_raw = 1'b0;
        n = 0;
        do begin step(); n++; end while (sensor_db && n < 20);
        chk("sensor_fall_latency", n, 6);
        chk("sensor_fall_no_rise", 32'(sensor_rise), 0);

        // press counter saturation and clear on service
        steps(5);
        repeat (20) press(6, 6);
`ifdef PRESS_COUNT_EN
        chk("press_count_sat", 32'(press_count), 15);
`else
        chk("press_count_off", 32'(press_count), 0);
`endif
        walk_ack = 1'b1; step();
        chk("press_count_clear", 32'(press_count), 0);
        walk_ack = 1'b0; steps(40);

        // randomized traffic on all inputs
        for (int c = 0; c < 3000; c++) begin
            if (wl == 0) begin walk_btn = ~walk_btn; wl = $urandom_range(1, 10); end
            if (sl == 0) begin sensor_raw = ~sensor_raw; sl = $urandom_range(1, 9); end
            if (al == 0) begin walk_ack = ~walk_ack; al = $urandom_range(5, 60); end
            wl--; sl--; al--;
            step();
        end

        walk_btn = 1'b0; sensor_raw = 1'b0; walk_ack = 1'b0;
        steps(5);
        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
